mem_ctrl: RTL and testbench

Memory-side responder for the load/store queue's memory request port. Accepts one single-cycle request (load or store, 1/2/4 bytes) and serializes it over the byte-wide synchronous RAM port, little-endian. Returns a one-cycle ready pulse with zero-extended read data; the queue does its own sign extension. Honours misbranch rollback for loads and stalls I/O-region writes while the UART buffer is full.

---
 rtl/mem_ctrl_pkg.sv | 31 +++
 rtl/mem_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state encoding and size decode for the memory-side responder.
package mem_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  // Request size encodings, in bytes
  localparam logic [2:0] SIZE_BYTE = 3'd1;
  localparam logic [2:0] SIZE_HALF = 3'd2;
  localparam logic [2:0] SIZE_WORD = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite
  } state_e;

  // Any encoding other than 1 or 2 bytes is serviced as a full word
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      SIZE_BYTE: return SIZE_BYTE;
      SIZE_HALF: return SIZE_HALF;
      default:   return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory-side responder: serializes 1/2/4-byte loads and stores over a byte-wide
// synchronous RAM port, little-endian, with rollback and I/O write back-pressure.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned IO_MASK_BIT = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_rollback,
  input  logic                  in_mem_ena,
  input  logic                  in_mem_iswrite,
  input  logic [ADDR_WIDTH-1:0] in_mem_addr,
  input  logic [DATA_WIDTH-1:0] in_mem_write_data,
  input  logic [2:0]            in_mem_size,
  output logic                  out_mem_ready,
  output logic [DATA_WIDTH-1:0] out_mem_read_data,
  input  logic [7:0]            in_ram_data,
  output logic [ADDR_WIDTH-1:0] out_ram_addr,
  output logic [7:0]            out_ram_data,
  output logic                  out_ram_wr,
  input  logic                  in_io_buffer_full
);

  function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
    return a[IO_MASK_BIT -: 2] == 2'b11;
  endfunction

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic [2:0]            issue_idx_q, issue_idx_d;  // next byte to put on the RAM port
  logic [1:0]            recv_idx_q, recv_idx_d;    // next lane to capture
  logic                  skip_q, skip_d;            // first READ edge has no data yet
  logic [23:0]           acc_q, acc_d;

  logic                  ready_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [ADDR_WIDTH-1:0] ram_addr_d;
  logic [7:0]            ram_data_d;
  logic                  ram_wr_d;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [7:0]            cur_byte;
  logic [1:0]            last_idx;
  logic [DATA_WIDTH-1:0] load_word;

  assign cur_addr = addr_q + ADDR_WIDTH'(issue_idx_q);
  assign last_idx = 2'(nbytes_q - 3'd1);

  // Byte-lane steering for the store byte currently being issued
  always_comb begin
    cur_byte = wdata_q[7:0];
    case (issue_idx_q[1:0])
      2'd0:    cur_byte = wdata_q[7:0];
      2'd1:    cur_byte = wdata_q[15:8];
      2'd2:    cur_byte = wdata_q[23:16];
      default: cur_byte = wdata_q[31:24];
    endcase
  end

  // Zero-extended load result; the final byte bypasses the accumulator
  always_comb begin
    load_word = ZERO_DATA;
    case (nbytes_q)
      SIZE_BYTE: load_word = {24'h0, in_ram_data};
      SIZE_HALF: load_word = {16'h0, in_ram_data, acc_q[7:0]};
      default:   load_word = {in_ram_data, acc_q};
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    nbytes_d    = nbytes_q;
    issue_idx_d = issue_idx_q;
    recv_idx_d  = recv_idx_q;
    skip_d      = skip_q;
    acc_d       = acc_q;
    ready_d     = FALSE;
    rdata_d     = ZERO_DATA;
    ram_addr_d  = out_ram_addr;
    ram_data_d  = out_ram_data;
    ram_wr_d    = FALSE;

    unique case (state_q)
      StIdle: begin
        if (in_mem_ena && !in_rollback) begin
          addr_d     = in_mem_addr;
          wdata_d    = in_mem_write_data;
          nbytes_d   = size_bytes(in_mem_size);
          recv_idx_d = 2'd0;
          skip_d     = TRUE;
          acc_d      = '0;
          if (in_mem_iswrite) begin
            state_d = StWrite;
            if (is_io(in_mem_addr) && in_io_buffer_full) begin
              issue_idx_d = 3'd0;
            end else begin
              ram_addr_d  = in_mem_addr;
              ram_data_d  = in_mem_write_data[7:0];
              ram_wr_d    = TRUE;
              issue_idx_d = 3'd1;
            end
          end else begin
            state_d     = StRead;
            ram_addr_d  = in_mem_addr;
            issue_idx_d = 3'd1;
          end
        end
      end

      StRead: begin
        if (in_rollback) begin
          state_d = StIdle;
          acc_d   = '0;
        end else begin
          if (issue_idx_q < nbytes_q) begin
            ram_addr_d  = cur_addr;
            issue_idx_d = issue_idx_q + 3'd1;
          end
          if (skip_q) begin
            skip_d = FALSE;
          end else if (recv_idx_q == last_idx) begin
            ready_d = TRUE;
            rdata_d = load_word;
            acc_d   = '0;
            state_d = StIdle;
          end else begin
            case (recv_idx_q)
              2'd0:    acc_d[7:0]   = in_ram_data;
              2'd1:    acc_d[15:8]  = in_ram_data;
              default: acc_d[23:16] = in_ram_data;
            endcase
            recv_idx_d = recv_idx_q + 2'd1;
          end
        end
      end

      StWrite: begin
        if (issue_idx_q < nbytes_q) begin
          // A full UART buffer holds an I/O byte back; retry it next cycle
          if (!(is_io(cur_addr) && in_io_buffer_full)) begin
            ram_addr_d  = cur_addr;
            ram_data_d  = cur_byte;
            ram_wr_d    = TRUE;
            issue_idx_d = issue_idx_q + 3'd1;
          end
        end else begin
          ready_d = TRUE;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= StIdle;
      addr_q            <= '0;
      wdata_q           <= '0;
      nbytes_q          <= SIZE_WORD;
      issue_idx_q       <= 3'd0;
      recv_idx_q        <= 2'd0;
      skip_q            <= FALSE;
      acc_q             <= '0;
      out_mem_ready     <= FALSE;
      out_mem_read_data <= ZERO_DATA;
      out_ram_addr      <= '0;
      out_ram_data      <= 8'h00;
      out_ram_wr        <= FALSE;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      wdata_q           <= wdata_d;
      nbytes_q          <= nbytes_d;
      issue_idx_q       <= issue_idx_d;
      recv_idx_q        <= recv_idx_d;
      skip_q            <= skip_d;
      acc_q             <= acc_d;
      out_mem_ready     <= ready_d;
      out_mem_read_data <= rdata_d;
      out_ram_addr      <= ram_addr_d;
      out_ram_data      <= ram_data_d;
      out_ram_wr        <= ram_wr_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, vector table, corner-case
// sequences and randomized traffic against a byte-array reference model.
module tb_mem_ctrl;

  localparam int TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_rollback;
  logic        in_mem_ena;
  logic        in_mem_iswrite;
  logic [31:0] in_mem_addr;
  logic [31:0] in_mem_write_data;
  logic [2:0]  in_mem_size;
  logic        out_mem_ready;
  logic [31:0] out_mem_read_data;
  logic [7:0]  in_ram_data;
  logic [31:0] out_ram_addr;
  logic [7:0]  out_ram_data;
  logic        out_ram_wr;
  logic        in_io_buffer_full;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_ctrl #(
    .ADDR_WIDTH (32),
    .IO_MASK_BIT(17)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_rollback      (in_rollback),
    .in_mem_ena       (in_mem_ena),
    .in_mem_iswrite   (in_mem_iswrite),
    .in_mem_addr      (in_mem_addr),
    .in_mem_write_data(in_mem_write_data),
    .in_mem_size      (in_mem_size),
    .out_mem_ready    (out_mem_ready),
    .out_mem_read_data(out_mem_read_data),
    .in_ram_data      (in_ram_data),
    .out_ram_addr     (out_ram_addr),
    .out_ram_data     (out_ram_data),
    .out_ram_wr       (out_ram_wr),
    .in_io_buffer_full(in_io_buffer_full)
  );

  // Synchronous byte RAM: registers the address, returns data one cycle later
  logic [7:0] ram   [logic [31:0]];
  logic [7:0] model [logic [31:0]];

  always @(posedge clk) begin
    logic [7:0] rd;
    rd = ram.exists(out_ram_addr) ? ram[out_ram_addr] : 8'h00;
    if (out_ram_wr) ram[out_ram_addr] = out_ram_data;
    in_ram_data <= rd;
  end

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return model.exists(a) ? model[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rbyte(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic int nbytes(input logic [2:0] sz);
    return (sz == 3'd1) ? 1 : (sz == 3'd2) ? 2 : 4;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    ram[a]   = v;
    model[a] = v;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One request. stall: full held high for the first `stall` edges from accept.
  // rb: edge offset from accept at which rollback is pulsed (<0 = never).
  // lat: edge offset at which ready was seen (TIMEOUT if never).
  task automatic run_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] sz, input int stall, input int rb,
                         output int lat, output logic [31:0] rd);
    int e;
    @(negedge clk);
    in_mem_ena        = 1'b1;
    in_mem_iswrite    = wr;
    in_mem_addr       = a;
    in_mem_write_data = d;
    in_mem_size       = sz;
    in_io_buffer_full = (stall > 0);
    in_rollback       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_mem_ena = 1'b0;
    e = 0;
    while (!out_mem_ready && e < TIMEOUT) begin
      in_io_buffer_full = (e + 1 < stall);
      in_rollback       = (e + 1 == rb);
      @(negedge clk);
      e++;
    end
    in_io_buffer_full = 1'b0;
    in_rollback       = 1'b0;
    lat = e;
    rd  = out_mem_read_data;
    @(negedge clk);
    check("ready_one_cycle", {31'h0, out_mem_ready}, 32'h0);
    check("rdata_zero_idle", out_mem_read_data, 32'h0);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    int          lat;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          lat;
    logic [31:0] rd;
    int          cnt_rdy;
    int          cnt_wr;

    rst = 1'b1; in_rollback = 0; in_mem_ena = 0; in_mem_iswrite = 0;
    in_mem_addr = 0; in_mem_write_data = 0; in_mem_size = 0; in_io_buffer_full = 0;

    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    preload(32'h104, 8'h55); preload(32'h105, 8'h66);
    preload(32'h201, 8'hF0);

    vecs[0] = '{1'b0, 32'h100,       32'h0,        3'd4, 5, 32'h44332211};
    vecs[1] = '{1'b0, 32'h201,       32'h0,        3'd1, 2, 32'h000000F0};
    vecs[2] = '{1'b1, 32'h40,        32'h1234ABCD, 3'd2, 2, 32'h0};
    vecs[3] = '{1'b0, 32'h40,        32'h0,        3'd2, 3, 32'h0000ABCD};
    vecs[4] = '{1'b0, 32'h100,       32'h0,        3'd3, 5, 32'h44332211};
    vecs[5] = '{1'b0, 32'h102,       32'h0,        3'd0, 5, 32'h66554433};
    vecs[6] = '{1'b1, 32'hFFFFFFFE,  32'hDEADBEEF, 3'd4, 4, 32'h0};
    vecs[7] = '{1'b0, 32'hFFFFFFFE,  32'h0,        3'd4, 5, 32'hDEADBEEF};
    vecs[8] = '{1'b0, 32'h1,         32'h0,        3'd1, 2, 32'h000000DE};
    vecs[9] = '{1'b1, 32'h30000,     32'h00000007, 3'd1, 1, 32'h0};

    // Reset values
    #12;
    check("rst_ready", {31'h0, out_mem_ready}, 32'h0);
    check("rst_rdata", out_mem_read_data, 32'h0);
    check("rst_ram_addr", out_ram_addr, 32'h0);
    check("rst_ram_data", {24'h0, out_ram_data}, 32'h0);
    check("rst_ram_wr", {31'h0, out_ram_wr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Word load address sequence: 0x100..0x103 after edges k..k+3
    in_mem_ena = 1; in_mem_iswrite = 0; in_mem_addr = 32'h100; in_mem_size = 3'd4;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_mem_ena = 0;
      check($sformatf("load_addr%0d", i), out_ram_addr, 32'h100 + i);
    end
    repeat (4) @(negedge clk);

    // Store half: byte stream on the RAM port
    in_mem_ena = 1; in_mem_iswrite = 1; in_mem_addr = 32'h40;
    in_mem_write_data = 32'h0000ABCD; in_mem_size = 3'd2;
    @(posedge clk);
    @(negedge clk);
    in_mem_ena = 0;
    check("sth_b0", {out_ram_wr, 15'h0, out_ram_addr[7:0], out_ram_data}, {1'b1, 15'h0, 8'h40, 8'hCD});
    @(negedge clk);
    check("sth_b1", {out_ram_wr, 15'h0, out_ram_addr[7:0], out_ram_data}, {1'b1, 15'h0, 8'h41, 8'hAB});
    @(negedge clk);
    check("sth_done", {30'h0, out_ram_wr, out_mem_ready}, 32'h1);
    model[32'h40] = 8'hCD; model[32'h41] = 8'hAB;
    @(negedge clk);

    // Vector table
    for (int v = 0; v < 10; v++) begin
      run_req(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].size, 0, -1, lat, rd);
      check($sformatf("vec%0d_lat", v), lat, vecs[v].lat);
      check($sformatf("vec%0d_data", v), rd, vecs[v].rdata);
      if (vecs[v].wr)
        for (int i = 0; i < nbytes(vecs[v].size); i++)
          model[vecs[v].addr + i] = vecs[v].wdata[8*i +: 8];
    end

    // I/O stall: full for 3 cycles delays the byte and the ready
    in_mem_ena = 1; in_mem_iswrite = 1; in_mem_addr = 32'h30000;
    in_mem_write_data = 32'h41; in_mem_size = 3'd1; in_io_buffer_full = 1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_mem_ena = 0;
      if (i == 2) in_io_buffer_full = 0;
      check($sformatf("io_stall_wr%0d", i), {31'h0, out_ram_wr}, 32'h0);
    end
    @(negedge clk);
    check("io_byte", {out_ram_wr, out_ram_addr[22:0], out_ram_data},
          {1'b1, 23'h30000, 8'h41});
    @(negedge clk);
    check("io_ready", {30'h0, out_ram_wr, out_mem_ready}, 32'h1);
    model[32'h30000] = 8'h41;
    @(negedge clk);
    check("io_mem", {24'h0, rbyte(32'h30000)}, 32'h41);

    // Load rolled back at k+2: no ready; next store completes
    run_req(1'b0, 32'h100, 32'h0, 3'd4, 0, 2, lat, rd);
    check("rb_load_no_ready", lat, TIMEOUT);
    run_req(1'b1, 32'h0, 32'h5A, 3'd1, 0, -1, lat, rd);
    check("rb_store_lat", lat, 1);
    check("rb_store_mem", {24'h0, rbyte(32'h0)}, 32'h5A);
    model[32'h0] = 8'h5A;

    // Store word with rollback at k+1 is unaffected
    run_req(1'b1, 32'h500, 32'h11223344, 3'd4, 0, 1, lat, rd);
    check("rb_store_word_lat", lat, 4);
    check("rb_store_word_mem", {rbyte(32'h503), rbyte(32'h502), rbyte(32'h501), rbyte(32'h500)},
          32'h11223344);
    for (int i = 0; i < 4; i++) model[32'h500 + i] = 8'h44 - 8'(i * 8'h11);

    // Rollback in IDLE drops the request
    @(negedge clk);
    in_mem_ena = 1; in_rollback = 1; in_mem_iswrite = 1; in_mem_addr = 32'h2000;
    in_mem_write_data = 32'h77; in_mem_size = 3'd1;
    @(posedge clk);
    @(negedge clk);
    in_mem_ena = 0; in_rollback = 0;
    cnt_rdy = 0; cnt_wr = 0;
    for (int i = 0; i < 8; i++) begin
      cnt_rdy += out_mem_ready;
      cnt_wr  += out_ram_wr;
      @(negedge clk);
    end
    check("idle_rb_ready", cnt_rdy, 0);
    check("idle_rb_wr", cnt_wr, 0);

    // Asynchronous reset during a load
    in_mem_ena = 1; in_mem_iswrite = 0; in_mem_addr = 32'h102; in_mem_size = 3'd4;
    @(posedge clk);
    @(negedge clk);
    in_mem_ena = 0;
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("arst_outs", {out_mem_ready, out_ram_wr, 6'h0, out_ram_data, out_ram_addr[15:0]}, 32'h0);
    check("arst_rdata", out_mem_read_data, 32'h0);
    @(negedge clk);
    rst = 0;
    cnt_rdy = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cnt_rdy += out_mem_ready;
    end
    check("arst_no_ready", cnt_rdy, 0);

    // Randomized traffic against the byte-array model
    for (int t = 0; t < 60; t++) begin
      logic        wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
      logic [2:0]  sz;
      int          region;
      int          stall;
      int          n;
      wr     = 1'($urandom_range(0, 1));
      region = $urandom_range(0, 2);
      a      = (region == 0) ? 32'h1000 + $urandom_range(0, 31) :
               (region == 1) ? 32'hFFFFFFFC + $urandom_range(0, 3) :
                               32'h30000 + $urandom_range(0, 15);
      sz     = 3'($urandom_range(0, 7));
      n      = nbytes(sz);
      d      = $urandom;
      stall  = (region == 2) ? $urandom_range(0, 3) : 0;
      run_req(wr, a, d, sz, stall, -1, lat, rd);
      exp = 32'h0;
      if (wr) begin
        for (int i = 0; i < n; i++) model[a + i] = d[8*i +: 8];
        check($sformatf("rnd%0d_st_lat", t), lat, n + stall);
      end else begin
        for (int i = 0; i < n; i++) exp = exp | ({24'h0, mbyte(a + i)} << (8 * i));
        check($sformatf("rnd%0d_ld_lat", t), lat, n + 1);
      end
      check($sformatf("rnd%0d_data", t), rd, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
